// File: rtl/tach_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tach_pkg
// Description : Width helpers and RPM scaling shared by the tachometer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package tach_pkg;

    // Bits needed to hold every value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int timer_width(input int window_cycles);
        return cnt_width(window_cycles - 1);
    endfunction

    // Full-width (count*mult)>>shift; the caller saturates to its output width.
    function automatic logic [63:0] rpm_scale(
        input logic [31:0] count,
        input logic [31:0] mult,
        input logic [5:0]  shift
    );
        logic [63:0] prod;
        prod = {32'd0, count} * {32'd0, mult};
        return prod >> shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tach_channel.sv
`default_nettype none
// ============================================================================
// Module      : tach_channel
// Description : One tachometer input: synchroniser, glitch filter, rising-edge
//               counter and zero-window (stall) counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tach_channel
    import tach_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int STALL_WINDOWS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             terminal,
    input  logic             pulse,
    output logic [CNT_W-1:0] count,
    output logic             count_sat,
    output logic             stalled
);

    localparam int FILT_W = cnt_width(FILTER_CYCLES);
    localparam int ZW_W   = cnt_width(STALL_WINDOWS);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [ZW_W-1:0]   ZW_MAX    = '1;
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [FILT_W-1:0] r_filt_cnt;
    logic [CNT_W-1:0]  r_count;
    logic [ZW_W-1:0]   r_zero_windows;

    logic w_differ;
    logic w_accept;
    logic w_rise;

    // The level flips on the FILTER_CYCLES-th consecutive differing clock, and
    // the edge is counted in that same clock.
    assign w_differ = (r_sync2 != r_level);
    assign w_accept = w_differ && (r_filt_cnt == FILT_LAST);
    assign w_rise   = w_accept && r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_level    <= 1'b0;
            r_filt_cnt <= '0;
        end else begin
            r_sync1 <= pulse;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_filt_cnt <= '0;
            end else if (w_accept) begin
                r_level    <= r_sync2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count        <= '0;
            r_zero_windows <= '0;
        end else if (!enable) begin
            r_count <= '0;
        end else if (terminal) begin
            // An edge on the terminal cycle opens the next window's count.
            r_count <= CNT_W'(w_rise);
            if (r_count == '0) begin
                if (r_zero_windows != ZW_MAX) begin
                    r_zero_windows <= r_zero_windows + ZW_W'(1);
                end
            end else begin
                r_zero_windows <= '0;
            end
        end else if (w_rise && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count     = r_count;
    assign count_sat = (r_count == CNT_MAX);
    assign stalled   = (r_zero_windows >= ZW_W'(STALL_WINDOWS));

endmodule
`default_nettype wire

// File: rtl/multi_tachometer_interface.sv
`default_nettype none
// ============================================================================
// Module      : multi_tachometer_interface
// Description : Gated-window RPM measurement over N_CH tachometer inputs with
//               a shared window timer and latched per-channel results.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_tachometer_interface
    import tach_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int WINDOW_CYCLES = 12_500_000,
    parameter int CNT_W         = 16,
    parameter int RPM_W         = 21,
    parameter int RPM_MULT      = 30,
    parameter int RPM_SHIFT     = 0,
    parameter int FILTER_CYCLES = 4,
    parameter int STALL_WINDOWS = 3
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic [N_CH-1:0]         tachometer_pulse_in,
    output logic [N_CH*RPM_W-1:0]   actual_rpm_out,
    output logic                    rpm_valid_out,
    output logic [N_CH-1:0]         stalled_out,
    output logic [N_CH-1:0]         overflow_out
);

    localparam int TMR_W = timer_width(WINDOW_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [63:0]      RPM_MAX  = (64'd1 << RPM_W) - 64'd1;

    logic [TMR_W-1:0] r_timer;
    logic             r_valid;
    logic [RPM_W-1:0] r_rpm [N_CH];
    logic [N_CH-1:0]  r_ovf;

    logic             w_terminal;
    logic [CNT_W-1:0] w_count     [N_CH];
    logic [N_CH-1:0]  w_count_sat;
    logic [63:0]      w_rpm_full  [N_CH];
    logic [N_CH-1:0]  w_rpm_sat;
    logic [RPM_W-1:0] w_rpm_next  [N_CH];

    assign w_terminal = enable_in && (r_timer == TMR_LAST);

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_channel
            tach_channel #(
                .CNT_W         (CNT_W),
                .FILTER_CYCLES (FILTER_CYCLES),
                .STALL_WINDOWS (STALL_WINDOWS)
            ) u_channel (
                .clk       (clk_in),
                .rst       (reset_in),
                .enable    (enable_in),
                .terminal  (w_terminal),
                .pulse     (tachometer_pulse_in[i]),
                .count     (w_count[i]),
                .count_sat (w_count_sat[i]),
                .stalled   (stalled_out[i])
            );

            assign w_rpm_full[i] = rpm_scale(32'(w_count[i]), 32'(RPM_MULT), 6'(RPM_SHIFT));
            assign w_rpm_sat[i]  = (w_rpm_full[i] > RPM_MAX);
            assign w_rpm_next[i] = w_rpm_sat[i] ? RPM_MAX[RPM_W-1:0] : w_rpm_full[i][RPM_W-1:0];
            assign actual_rpm_out[i*RPM_W +: RPM_W] = r_rpm[i];
        end
    endgenerate

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_timer <= '0;
            r_valid <= 1'b0;
            r_ovf   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_rpm[i] <= '0;
            end
        end else begin
            r_valid <= w_terminal;
            if (!enable_in || w_terminal) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (w_terminal) begin
                for (int i = 0; i < N_CH; i++) begin
                    r_rpm[i] <= w_rpm_next[i];
                    r_ovf[i] <= w_count_sat[i] || w_rpm_sat[i];
                end
            end
        end
    end

    assign rpm_valid_out = r_valid;
    assign overflow_out  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multi_tachometer_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_tachometer_interface
// Description : Directed, table-driven bench for multi_tachometer_interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_tachometer_interface;

    localparam int RPM_W = 21;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [1:0]         pin;
    logic [2*RPM_W-1:0] rpm;
    logic               valid;
    logic [1:0]         stalled;
    logic [1:0]         ovf;

    int checks = 0;
    int errors = 0;

    multi_tachometer_interface #(
        .N_CH          (2),
        .WINDOW_CYCLES (1000),
        .CNT_W         (4),
        .RPM_W         (RPM_W),
        .RPM_MULT      (30),
        .RPM_SHIFT     (0),
        .FILTER_CYCLES (4),
        .STALL_WINDOWS (3)
    ) dut (
        .clk_in              (clk),
        .reset_in            (rst),
        .enable_in           (en),
        .tachometer_pulse_in (pin),
        .actual_rpm_out      (rpm),
        .rpm_valid_out       (valid),
        .stalled_out         (stalled),
        .overflow_out        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n0;
        int         hi0;
        int         lo0;
        bit         glitch1;
        int         n1;
        int         exp_rpm0;
        int         exp_rpm1;
        logic [1:0] exp_ovf;
        logic [1:0] exp_stall;
    } row_t;

    row_t rows [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic pulse_at(input int c, input int n, input int hi, input int lo);
        int p;
        p = hi + lo;
        return (n > 0) && (c >= 0) && (c / p < n) && (c % p < hi);
    endfunction

    function automatic logic ch1_at(input int c, input bit glitch, input int n);
        return glitch ? ((c % 50) < 3) : pulse_at(c, n, 20, 80);
    endfunction

    function automatic int rpm0();
        return int'(rpm[RPM_W-1:0]);
    endfunction

    function automatic int rpm1();
        return int'(rpm[2*RPM_W-1:RPM_W]);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        int vpos;
        int n;
        int ra;
        int rb;

        // n0 hi0 lo0 glitch1 n1 rpm0 rpm1 ovf stall  (bit1 = ch1, bit0 = ch0)
        rows[0] = '{10, 30, 70, 1'b1, 0, 300,   0, 2'b00, 2'b00};
        rows[1] = '{10, 30, 70, 1'b1, 0, 300,   0, 2'b00, 2'b00};
        rows[2] = '{10, 30, 70, 1'b1, 0, 300,   0, 2'b00, 2'b10};
        rows[3] = '{20, 10, 20, 1'b1, 0, 450,   0, 2'b01, 2'b10};
        rows[4] = '{10, 30, 70, 1'b0, 5, 300, 150, 2'b00, 2'b00};
        rows[5] = '{ 0, 30, 70, 1'b0, 3,   0,  90, 2'b00, 2'b00};

        rst = 1'b1;
        en  = 1'b0;
        pin = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rpm",     64'(rpm),     64'd0);
        check("reset_valid",   64'(valid),   64'd0);
        check("reset_stalled", 64'(stalled), 64'd0);
        check("reset_ovf",     64'(ovf),     64'd0);

        rst = 1'b0;
        vcount = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        check("idle_no_valid", 64'(vcount), 64'd0);

        // Each row drives exactly one window, aligned to the timer.
        en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            vcount = 0;
            vpos   = -1;
            for (int j = 0; j < 1000; j++) begin
                pin = {ch1_at(j, rows[r].glitch1, rows[r].n1),
                       pulse_at(j, rows[r].n0, rows[r].hi0, rows[r].lo0)};
                @(posedge clk);
                #1;
                if (valid) begin
                    vcount++;
                    vpos = j;
                end
            end
            check($sformatf("row%0d_valid_count", r), 64'(vcount), 64'd1);
            check($sformatf("row%0d_valid_pos", r),   64'(vpos),   64'd999);
            check($sformatf("row%0d_rpm0", r),        64'(rpm0()), 64'(rows[r].exp_rpm0));
            check($sformatf("row%0d_rpm1", r),        64'(rpm1()), 64'(rows[r].exp_rpm1));
            check($sformatf("row%0d_ovf", r),         64'(ovf),     64'(rows[r].exp_ovf));
            check($sformatf("row%0d_stalled", r),     64'(stalled), 64'(rows[r].exp_stall));
        end

        // Disable mid-window: the partial window is dropped, outputs hold.
        for (int j = 0; j < 500; j++) begin
            pin = {1'b0, pulse_at(j, 2, 20, 80)};
            @(posedge clk);
            #1;
        end
        en = 1'b0;
        vcount = 0;
        for (int j = 0; j < 3000; j++) begin
            pin = {1'b0, pulse_at(j, 20, 20, 80)};
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        check("disabled_no_valid", 64'(vcount), 64'd0);
        check("disabled_rpm_held", 64'(rpm), {22'd0, 21'd90, 21'd0});
        check("disabled_flags_held", 64'({stalled, ovf}), 64'd0);

        // n counts enabled cycles with the first enabled cycle as 1.
        en  = 1'b1;
        pin = 2'b00;
        n   = 1;
        while (!valid && n < 3000) begin
            pin[0] = pulse_at(n - 10, 4, 20, 80);
            @(posedge clk);
            #1;
            n++;
        end
        check("reenable_latency", 64'(n),      64'd1001);
        check("reenable_rpm0",    64'(rpm0()), 64'd120);
        check("reenable_rpm1",    64'(rpm1()), 64'd0);
        check("reenable_stalled", 64'(stalled), 64'd0);

        // Third pulse is filtered exactly on the terminal cycle (timer=999).
        vcount = 0;
        ra = -1;
        rb = -1;
        for (int j = 0; j < 2000; j++) begin
            pin = {1'b0, ((j >= 100 && j < 120) || (j >= 300 && j < 320) || (j >= 994 && j < 1014))};
            @(posedge clk);
            #1;
            if (valid) begin
                vcount++;
                if (j == 999)  ra = rpm0();
                if (j == 1999) rb = rpm0();
            end
        end
        check("terminal_valid_count", 64'(vcount), 64'd2);
        check("terminal_rpm_current", 64'(ra),     64'd60);
        check("terminal_rpm_next",    64'(rb),     64'd30);
        check("terminal_stalled",     64'(stalled), 64'd2);

        // Reset at timer=500 with counts pending.
        for (int j = 0; j < 500; j++) begin
            pin = {1'b0, pulse_at(j, 3, 20, 80)};
            @(posedge clk);
            #1;
        end
        pin = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check("midreset_rpm",     64'(rpm),     64'd0);
        check("midreset_valid",   64'(valid),   64'd0);
        check("midreset_stalled", 64'(stalled), 64'd0);
        check("midreset_ovf",     64'(ovf),     64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 1;
        while (!valid && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("postreset_latency", 64'(n),       64'd1001);
        check("postreset_rpm",     64'(rpm),     64'd0);
        check("postreset_stalled", 64'(stalled), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_tachometer_interface.md
MULTI_TACHOMETER_INTERFACE -- requirements
Module: multi_tachometer_interface

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent tachometer channels.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 12_500_000: gate window length in clocks (100 ms at 125 MHz).
REQ-003 SHALL have parameter CNT_W, default 16: per-channel edge counter width.
REQ-004 SHALL have parameter RPM_W, default 21: RPM output width.
REQ-005 SHALL have parameter RPM_MULT, default 30, and parameter RPM_SHIFT, default 0: the scaling rpm = (count*RPM_MULT)>>RPM_SHIFT.
REQ-006 SHALL have parameter FILTER_CYCLES, default 4: clocks a synchronised input must be stable before it is accepted.
REQ-007 SHALL have parameter STALL_WINDOWS, default 3: consecutive zero-count windows before a channel is declared stalled.
REQ-008 SHALL have port clk_in, input, 1: the single clock.
REQ-009 SHALL have port reset_in, input, 1: the asynchronous, active-high reset.
REQ-010 SHALL have port enable_in, input, 1: measurement enable.
REQ-011 SHALL have port tachometer_pulse_in, input, N_CH: raw asynchronous pulses, one bit per channel.
REQ-012 SHALL have port actual_rpm_out, output, N_CH x RPM_W: latched RPM per channel.
REQ-013 SHALL have port rpm_valid_out, output, 1: one-cycle strobe when actual_rpm_out updates.
REQ-014 SHALL have port stalled_out, output, N_CH: per-channel stall flag.
REQ-015 SHALL have port overflow_out, output, N_CH: per-channel flag, set when the last window's count or RPM saturated.

Function
REQ-016 SHALL pass each tachometer_pulse_in bit through a two-flop synchroniser.
REQ-017 SHALL change a channel's filtered level only after the synchronised level has differed from it for FILTER_CYCLES consecutive clocks; shorter glitches SHALL be ignored.
REQ-018 SHALL count one edge per filtered 0->1 transition; the counter SHALL saturate at 2^CNT_W-1.
REQ-019 SHALL run a shared window timer 0..WINDOW_CYCLES-1 while enable_in=1; the terminal cycle is timer=WINDOW_CYCLES-1.
REQ-020 SHALL, on the terminal cycle, compute per channel (count*RPM_MULT)>>RPM_SHIFT at full width and saturate it to 2^RPM_W-1.
REQ-021 SHALL register that result into actual_rpm_out, with rpm_valid_out=1 for exactly one clock, one cycle after the terminal cycle.
REQ-022 SHALL restart the counters at 0 after the terminal cycle; an edge detected on the terminal cycle itself SHALL count in the new window (counter loads 1).
REQ-023 SHALL set overflow_out[i] at each update to 1 if counter or RPM saturated in that window, else 0.
REQ-024 SHALL keep a per-channel zero-window counter that increments (saturating) on each update with count 0 and clears on a nonzero count; stalled_out[i]=1 while it is >= STALL_WINDOWS.
REQ-025 SHALL, while enable_in=0, hold the timer and counters at 0, hold actual_rpm_out, stalled_out and overflow_out, and keep rpm_valid_out at 0; synchroniser and filter keep running.
REQ-026 SHALL start a full fresh window at timer=0 on the first clock with enable_in=1.
REQ-027 SHALL keep end-to-end input latency at 2 (sync) + FILTER_CYCLES clocks from pin edge to count.

Reset
REQ-028 SHALL, on reset_in=1, asynchronously clear the timer, counters, zero-window counters, synchroniser and filter state (level 0), actual_rpm_out, rpm_valid_out, stalled_out and overflow_out to 0.
REQ-029 SHALL treat a reset asserted mid-window as discarding that window; after release, the first update occurs WINDOW_CYCLES+1 clocks after the first enabled clock.

Structure
REQ-030 SHALL place the window/stall counter width helpers and the RPM scaling function in package tach_pkg.
REQ-031 SHALL instantiate per-channel logic (synchroniser, filter, edge counter, stall counter) as sub-module tach_channel via a generate loop, with the window timer and output registers in the top level.

Verification (bench: WINDOW_CYCLES=1000, FILTER_CYCLES=4, RPM_MULT=30, RPM_SHIFT=0, N_CH=2)
REQ-032 SHALL cover: ch0 pulses 30 high/70 low continuously -> each update actual_rpm_out[0]=300 and rpm_valid_out high exactly one clock every 1000 clocks.
REQ-033 SHALL cover: ch1 3-cycle glitches every 50 clocks -> actual_rpm_out[1]=0 and stalled_out[1]=1 after the third update.
REQ-034 SHALL cover: CNT_W=4 with 20 pulses per window -> count saturates at 15, rpm=450, overflow_out=1; the next window with 10 pulses gives rpm=300, overflow_out=0.
REQ-035 SHALL cover: enable_in low for 3000 clocks mid-window -> no rpm_valid_out, outputs held; on re-enable the next update arrives 1001 clocks later.
REQ-036 SHALL cover: reset_in pulsed at timer=500 -> all outputs 0 immediately, and the first update arrives 1001 clocks after release with enable_in=1.
REQ-037 SHALL cover: a filtered edge landing on the terminal cycle -> excluded from the current rpm and counted in the next window.
